mmu_sel_ctrl: RTL and testbench
===============================

Name: mmu_sel_ctrl

Overview:
- Synchronous controller that sequences the MMU's 2-way click-based selector from the clocked domain.
- Arbitrates round-robin among NUM_PORTS requesters and drives the selector's select lines.
- Issues one drive request per transaction and waits for the selector's free completion, using a synchronizer.
- Reports per-port completion (ack) and a sticky timeout when the asynchronous side never frees.

Parameters:
- NUM_PORTS, 2, number of requesters (one-hot select width).
- TO_W, 8, width of the timeout counter and cfg_timeout.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  NUM_PORTS  level request per port; sampled only in IDLE.
- o_ack  out  NUM_PORTS  one-hot, one-cycle pulse: granted transaction completed.
- o_select  out  NUM_PORTS  one-hot select to the selector; stable SETUP..WAIT.
- o_drive  out  1  one-cycle drive pulse to the selector.
- i_free  in  1  asynchronous completion pulse from the selector. Constraint: high ≥ 2 clk periods.
- cfg_timeout  in  TO_W  WAIT cycles before abort; 0 = timeout disabled.
- o_busy  out  1  high in SETUP, DRIVE, WAIT.
- o_timeout  out  1  sticky abort flag; cleared only by rst.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, o_select=0, o_drive=0, o_ack=0, o_busy=0, o_timeout=0, rr_ptr=0, sync flops=0, counter=0.
- rst asserted mid-transaction forces the reset values on the next edge. No ack is issued; the asynchronous side is not cancelled.
- FSM transitions:
  - IDLE: if |i_req, grant the first requesting port in priority order rr_ptr, rr_ptr+1, …, wrapping mod NUM_PORTS. Latch one-hot into o_select and go to SETUP. Otherwise o_select=0 and stay in IDLE.
  - SETUP: exactly 1 cycle; o_select stable, o_drive=0 (select setup margin) -> DRIVE.
  - DRIVE: o_drive=1 for exactly this cycle; counter cleared -> WAIT.
  - WAIT: o_select held; counter increments each cycle, saturating at all-ones. On free_pulse: o_ack[granted]=1 in the next cycle, rr_ptr=granted+1 mod NUM_PORTS, -> IDLE.
- Timeout: in WAIT, if cfg_timeout!=0 and counter==cfg_timeout-1 with no free_pulse, then:
  - set o_timeout, no ack;
  - rr_ptr advances as on completion;
  - -> IDLE.
- Simultaneous free_pulse and timeout terminal count: free wins (ack, no timeout).
- free_pulse path: i_free passes through a 2-flop synchronizer, then rising-edge detect (registered). free_pulse is high 1 cycle, 3 edges after i_free first sampled high.
- free_pulse outside WAIT (spurious or late after timeout) is ignored; no state change.
- i_req deassertion after grant is ignored; the transaction completes. Requests are never queued; a requester holds i_req until its ack.
- Ack cycle is an IDLE cycle; arbitration in that same cycle uses the updated rr_ptr. Back-to-back grant is therefore possible: ack and SETUP entry occur on consecutive edges.
- Minimum transaction length: IDLE→SETUP→DRIVE→WAIT (≥3 cycles incl. sync latency)→IDLE.
- o_drive is never asserted unless o_select is one-hot nonzero.
- o_select and o_ack are always one-hot or zero.

Decomposition:
- Package mmu_sel_pkg: state enum (IDLE, SETUP, DRIVE, WAIT) with 2-bit encoding; default TO_W; function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module mmu_pulse_sync: 2-flop synchronizer plus rising-edge detector, with sync active-high rst. Reused for other click-to-clock completion crossings.

Test Plan:
- Reset: hold rst 3 cycles with i_req=2'b11 -> all outputs 0, no drive; after release, first grant goes to port0 (o_select=2'b01).
- Single request: i_req=2'b10; bench raises i_free 4 cycles after o_drive for 3 cycles -> o_select=2'b10 one cycle before o_drive; o_ack=2'b10 one cycle, 4 edges after i_free rises; o_busy drops with the ack.
- Round-robin fairness: i_req=2'b11 held for 6 transactions -> grants alternate 01,10,01,10,01,10; each ack immediately followed by the next SETUP.
- Timeout: cfg_timeout=8, i_free held 0 -> o_timeout rises 8 cycles after the DRIVE cycle, no ack, FSM to IDLE. A later i_free pulse is ignored. o_timeout stays 1 until rst.
- Race: cfg_timeout=5 with free_pulse landing on the terminal cycle -> ack issued, o_timeout stays 0. With cfg_timeout=0 and free after 300 cycles -> ack, no timeout.
- Reset in WAIT: assert rst 1 cycle during WAIT -> next edge all outputs 0, rr_ptr=0. A subsequent i_free pulse produces no ack.

Source files
------------

// File: rtl/mmu_sel_pkg.sv
// Shared types and helpers for the MMU selector controller.
package mmu_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int DEF_TO_W  = 8;
  // Widest requester vector rr_pick handles; callers zero-pad to this.
  localparam int MAX_PORTS = 32;

  // First requester at or after ptr, wrapping mod n; returns one-hot (or 0).
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input int ptr, input int n);
    logic [MAX_PORTS-1:0] gnt;
    logic [4:0]           idx;
    logic                 found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < n && !found) begin
        idx = 5'((ptr + k) % n);
        if (req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mmu_pulse_sync.sv
// Brings an asynchronous completion pulse into the clk domain: two-flop
// synchronizer followed by a registered rising-edge detector. The output
// is a single-cycle pulse three edges after the input is first sampled.
module mmu_pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       pulse_q, pulse_d;

  // Shift the synchronizer and detect a 0->1 transition on its output.
  always_comb begin
    sync_d  = {sync_q[0], i_async};
    prev_d  = sync_q[1];
    pulse_d = sync_q[1] & ~prev_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/mmu_sel_ctrl.sv
// Sequences the 2-way click-based selector: round-robin grant, select setup,
// one drive pulse, then wait for the synchronized free completion or abort
// on timeout.
module mmu_sel_ctrl
  import mmu_sel_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TO_W      = DEF_TO_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_ack,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_drive,
  input  logic                 i_free,
  input  logic [TO_W-1:0]      cfg_timeout,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 free_pulse;
  logic [MAX_PORTS-1:0] req_w, gnt_w;
  logic [NUM_PORTS-1:0] pick;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     nxt_ptr;
  logic                 to_hit;
  logic                 unused_gnt;

  mmu_pulse_sync u_free_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_free),
    .o_pulse (free_pulse)
  );

  // Round-robin pick from the current pointer, plus its binary index.
  always_comb begin
    req_w                = '0;
    req_w[NUM_PORTS-1:0] = i_req;
    gnt_w                = rr_pick(req_w, int'(rr_ptr_q), NUM_PORTS);
    pick                 = gnt_w[NUM_PORTS-1:0];
    pick_idx             = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign unused_gnt = ^gnt_w;

  // Pointer moves past the granted port whether it completed or timed out.
  assign nxt_ptr = (gnt_idx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
  assign to_hit  = (cfg_timeout != '0) && (cnt_q == cfg_timeout - TO_W'(1));

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ack_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          sel_d     = pick;
          gnt_idx_d = pick_idx;
          state_d   = ST_SETUP;
        end else begin
          sel_d = '0;
        end
      end
      ST_SETUP: state_d = ST_DRIVE;
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
        // Free has priority over a timeout on the same cycle.
        if (free_pulse) begin
          ack_d    = sel_q;
          rr_ptr_d = nxt_ptr;
          sel_d    = '0;
          state_d  = ST_IDLE;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          rr_ptr_d  = nxt_ptr;
          sel_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      ack_q     <= '0;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_select  = sel_q;
  assign o_ack     = ack_q;
  assign o_drive   = (state_q == ST_DRIVE);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_mmu_sel_ctrl.sv
// Self-checking bench for mmu_sel_ctrl with a transaction-level model.
module tb_mmu_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_req;
  logic [1:0] o_ack, o_select;
  logic       o_drive, i_free, o_busy, o_timeout;
  logic [7:0] cfg_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and sticky timeout.
  int   m_ptr;
  logic m_to;

  always #5 clk = ~clk;

  mmu_sel_ctrl #(.NUM_PORTS(2), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_ack(o_ack), .o_select(o_select),
    .o_drive(o_drive), .i_free(i_free), .cfg_timeout(cfg_timeout),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  // Invariants: select/ack one-hot or zero, drive only with a one-hot select.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (o_select == 2'b11 || o_ack == 2'b11 || (o_drive && o_select == 2'b00)) begin
        errors++;
        $display("FAIL invariant sel=%b ack=%b drive=%b", o_select, o_ack, o_drive);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // First requesting port from ptr, wrapping over 2 ports.
  function automatic int m_pick(input logic [1:0] req, input int ptr);
    int p;
    for (int k = 0; k < 2; k++) begin
      p = (ptr + k) % 2;
      if (req[p[0]]) return p;
    end
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  // Runs one transaction from the current negedge. i_free rises at offset
  // 'delay' after the DRIVE cycle (negative = never) for 'flen' cycles.
  // Returns at the negedge of the cycle where the FSM is back in IDLE.
  task automatic run_txn(input int delay, input int flen, input int limit,
                         output int wait_cyc, output logic [1:0] g, output int drv_ok,
                         output int end_off, output logic [1:0] ack_v, output logic to_start,
                         output logic to_end, output logic [1:0] sel_end, output int sel_bad);
    int t;
    g = 2'b00; drv_ok = 0; end_off = -1; ack_v = 2'b00; to_start = 1'b0;
    to_end = 1'b0; sel_end = 2'b00; sel_bad = 0; t = 0;
    @(negedge clk); t++;
    while (o_select == 2'b00 && t < 20) begin @(negedge clk); t++; end
    wait_cyc = t;
    if (o_select == 2'b00) return;
    g = o_select;
    if (o_drive) sel_bad++;
    @(negedge clk);
    if (!o_drive) return;
    drv_ok   = 1;
    to_start = o_timeout;
    if (o_select !== g) sel_bad++;
    for (int k = 1; k <= limit; k++) begin
      if (k - 1 == delay) i_free = 1'b1;
      if (k - 1 == delay + flen) i_free = 1'b0;
      @(negedge clk);
      if (o_drive) sel_bad++;
      if (!o_busy) begin
        end_off = k; ack_v = o_ack; to_end = o_timeout; sel_end = o_select;
        break;
      end
      if (o_select !== g || o_ack != 2'b00) sel_bad++;
    end
    i_free = 1'b0;
  endtask

  int w, d_ok, e_off, s_bad;
  logic [1:0] g, a_v, s_end;
  logic t_st, t_end;

  task automatic test_reset();
    rst = 1'b1; i_req = 2'b11; i_free = 1'b0; cfg_timeout = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({o_select, o_ack, o_drive, o_busy, o_timeout} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0", i, {o_select, o_ack, o_drive, o_busy, o_timeout});
      end
    end
    rst = 1'b0; m_ptr = 0; m_to = 1'b0;
    run_txn(0, 2, 20, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== 2'b01 || w != 1 || d_ok != 1 || e_off != 4 || a_v !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant g=%b w=%0d drv=%0d end=%0d ack=%b exp g=01 w=1 drv=1 end=4 ack=01",
               g, w, d_ok, e_off, a_v);
    end
    m_ptr = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int p;
    i_req = 2'b10;
    p = m_pick(i_req, m_ptr);
    run_txn(4, 3, 30, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== onehot(p) || w != 1 || d_ok != 1 || s_bad != 0) begin
      errors++;
      $display("FAIL single_grant g=%b w=%0d drv=%0d bad=%0d exp g=%b w=1 drv=1 bad=0", g, w, d_ok, s_bad, onehot(p));
    end
    checks++;
    if (e_off != 8 || a_v !== onehot(p) || s_end !== 2'b00 || t_end !== 1'b0) begin
      errors++;
      $display("FAIL single_ack end=%0d ack=%b sel=%b to=%b exp end=8 ack=%b sel=00 to=0", e_off, a_v, s_end, t_end, onehot(p));
    end
    m_ptr = (p + 1) % 2;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int p;
    i_req = 2'b11;
    for (int n = 0; n < 6; n++) begin
      p = m_pick(i_req, m_ptr);
      run_txn(0, 2, 20, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
      if (n == 5) i_req = 2'b00;
      checks++;
      if (g !== onehot(p) || w != 1 || d_ok != 1 || e_off != 4 || a_v !== onehot(p) || s_bad != 0) begin
        errors++;
        $display("FAIL rr_txn%0d g=%b w=%0d drv=%0d end=%0d ack=%b bad=%0d exp g=%b w=1 drv=1 end=4 ack=%b",
                 n, g, w, d_ok, e_off, a_v, s_bad, onehot(p), onehot(p));
      end
      m_ptr = (p + 1) % 2;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_race();
    int p;
    // Free pulse lands on the terminal-count cycle: free wins.
    cfg_timeout = 8'd5; i_req = 2'b01;
    p = m_pick(i_req, m_ptr);
    run_txn(2, 3, 20, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== onehot(p) || e_off != 6 || a_v !== onehot(p) || t_end !== 1'b0) begin
      errors++;
      $display("FAIL race_terminal g=%b end=%0d ack=%b to=%b exp g=%b end=6 ack=%b to=0", g, e_off, a_v, t_end, onehot(p), onehot(p));
    end
    m_ptr = (p + 1) % 2;
    repeat (4) @(negedge clk);
    // Timeout disabled: a very late free still completes.
    cfg_timeout = 8'd0; i_req = 2'b10;
    p = m_pick(i_req, m_ptr);
    run_txn(300, 3, 320, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== onehot(p) || e_off != 304 || a_v !== onehot(p) || t_end !== 1'b0 || s_bad != 0) begin
      errors++;
      $display("FAIL race_disabled g=%b end=%0d ack=%b to=%b bad=%0d exp end=304 ack=%b to=0", g, e_off, a_v, t_end, s_bad, onehot(p));
    end
    m_ptr = (p + 1) % 2;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int p, bad;
    cfg_timeout = 8'd8; i_req = 2'b01;
    p = m_pick(i_req, m_ptr);
    run_txn(-1, 0, 20, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== onehot(p) || t_st !== 1'b0 || e_off != 9 || t_end !== 1'b1 || a_v !== 2'b00) begin
      errors++;
      $display("FAIL timeout_abort g=%b to0=%b end=%0d to=%b ack=%b exp to0=0 end=9 to=1 ack=00", g, t_st, e_off, t_end, a_v);
    end
    m_ptr = (p + 1) % 2; m_to = 1'b1;
    // Late free after the abort must be ignored.
    bad = 0;
    i_free = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) i_free = 1'b0;
      @(negedge clk);
      if (o_ack != 2'b00 || o_busy) bad++;
    end
    checks++;
    if (bad != 0 || o_timeout !== m_to) begin
      errors++;
      $display("FAIL timeout_late_free bad=%0d to=%b exp bad=0 to=%b", bad, o_timeout, m_to);
    end
  endtask

  task automatic test_reset_in_wait();
    int t, bad, p;
    cfg_timeout = 8'd0; i_req = 2'b10;
    t = 0;
    @(negedge clk);
    while (!o_drive && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (!o_drive || o_select !== 2'b10) begin
      errors++;
      $display("FAIL rstwait_drive drive=%b sel=%b exp drive=1 sel=10", o_drive, o_select);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_select, o_ack, o_drive, o_busy, o_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL rstwait_outputs got=%b exp=0", {o_select, o_ack, o_drive, o_busy, o_timeout});
    end
    rst = 1'b0; i_req = 2'b00; m_ptr = 0; m_to = 1'b0;
    bad = 0;
    i_free = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) i_free = 1'b0;
      @(negedge clk);
      if (o_ack != 2'b00 || o_busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstwait_free_ignored bad=%0d exp 0", bad);
    end
    i_req = 2'b11;
    p = m_pick(i_req, m_ptr);
    run_txn(0, 2, 20, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
    i_req = 2'b00;
    checks++;
    if (g !== onehot(p) || e_off != 4 || a_v !== onehot(p)) begin
      errors++;
      $display("FAIL rstwait_ptr g=%b end=%0d ack=%b exp g=%b end=4 ack=%b", g, e_off, a_v, onehot(p), onehot(p));
    end
    m_ptr = (p + 1) % 2;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int p, cfg, dly, flen, exp_end;
    logic exp_to;
    for (int n = 0; n < 24; n++) begin
      cfg  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 12));
      dly  = int'($urandom_range(0, 10));
      flen = int'($urandom_range(2, 4));
      exp_to = (cfg != 0) && (dly + 3 > cfg);
      if (exp_to) dly = -1;
      exp_end = exp_to ? cfg + 1 : dly + 4;
      cfg_timeout = 8'(cfg);
      i_req = 2'($urandom_range(1, 3));
      p = m_pick(i_req, m_ptr);
      run_txn(dly, flen, 40, w, g, d_ok, e_off, a_v, t_st, t_end, s_end, s_bad);
      i_req = 2'b00;
      if (exp_to) m_to = 1'b1;
      checks++;
      if (g !== onehot(p) || w != 1 || d_ok != 1 || e_off != exp_end || s_bad != 0 ||
          a_v !== (exp_to ? 2'b00 : onehot(p)) || t_end !== m_to) begin
        errors++;
        $display("FAIL rand%0d cfg=%0d dly=%0d g=%b w=%0d drv=%0d end=%0d ack=%b to=%b bad=%0d exp g=%b end=%0d ack=%b to=%b",
                 n, cfg, dly, g, w, d_ok, e_off, a_v, t_end, s_bad, onehot(p), exp_end,
                 exp_to ? 2'b00 : onehot(p), m_to);
      end
      m_ptr = (p + 1) % 2;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 2'b00; i_free = 1'b0; cfg_timeout = 8'd0;
    m_ptr = 0; m_to = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_race();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
